// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types, defaults and saturating add for the LIF neuron array
// Optional spike counters are enabled with LIF_SPIKE_COUNT_EN.
package lif_pkg;

  typedef enum logic {LIF_INTEGRATE, LIF_REFRAC} lif_state_t;

  localparam int LIF_WIDTH         = 8;
  localparam int LIF_N_CH          = 2;
  localparam int LIF_LEAK_SHIFT    = 3;
  localparam int LIF_REFRAC_CYCLES = 4;
  localparam int LIF_SAT_W         = 32;

  // One extra bit of headroom catches the carry so the result clips instead of wrapping.
  function automatic logic [LIF_SAT_W-1:0] lif_sat_add(
    input logic [LIF_SAT_W-1:0] a,
    input logic [LIF_SAT_W-1:0] b,
    input int                   width
  );
    logic [LIF_SAT_W:0] sum;
    logic [LIF_SAT_W:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = ((LIF_SAT_W+1)'(1) << width) - (LIF_SAT_W+1)'(1);
    return (sum > max_v) ? max_v[LIF_SAT_W-1:0] : sum[LIF_SAT_W-1:0];
  endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// rtl/lif_neuron_array_if.sv - pin bundle between the wrapper and the neuron array
// Carries cnt_clr/spike_cnt only when LIF_SPIKE_COUNT_EN is defined.
interface lif_neuron_array_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 2
) ();

  logic                   en;
  logic [N_CH*WIDTH-1:0]  i_syn;
  logic [WIDTH-1:0]       thresh;
  logic [N_CH*WIDTH-1:0]  v_mem;
  logic [N_CH-1:0]        spike;
  logic [N_CH-1:0]        refrac;
`ifdef LIF_SPIKE_COUNT_EN
  logic                   cnt_clr;
  logic [N_CH*8-1:0]      spike_cnt;

  modport master (output en, i_syn, thresh, cnt_clr, input v_mem, spike, refrac, spike_cnt);
  modport slave  (input en, i_syn, thresh, cnt_clr, output v_mem, spike, refrac, spike_cnt);
`else
  modport master (output en, i_syn, thresh, input v_mem, spike, refrac);
  modport slave  (input en, i_syn, thresh, output v_mem, spike, refrac);
`endif

endinterface

// File: rtl/lif_channel.sv
// rtl/lif_channel.sv - one leaky integrate-and-fire neuron with refractory timing
// Optional saturating spike counter under LIF_SPIKE_COUNT_EN.
module lif_channel
  import lif_pkg::*;
#(
  parameter int WIDTH         = LIF_WIDTH,
  parameter int LEAK_SHIFT    = LIF_LEAK_SHIFT,
  parameter int REFRAC_CYCLES = LIF_REFRAC_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] i_syn,
  input  logic [WIDTH-1:0] thresh,
`ifdef LIF_SPIKE_COUNT_EN
  input  logic             cnt_clr,
  output logic [7:0]       spike_cnt,
`endif
  output logic [WIDTH-1:0] v_mem,
  output logic             spike,
  output logic             refrac
);

  localparam int CNT_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

  lif_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] leaked;
  logic [WIDTH-1:0] v_next;
  logic             fire;

  // Leak never underflows since v >> LEAK_SHIFT <= v.
  assign leaked = v - (v >> LEAK_SHIFT);
  assign v_next = WIDTH'(lif_sat_add(LIF_SAT_W'(leaked), LIF_SAT_W'(i_syn), WIDTH));
  assign fire   = (thresh != '0) && (v_next >= thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LIF_INTEGRATE;
      cnt   <= '0;
      v     <= '0;
      spike <= 1'b0;
    end else if (en) begin
      case (state)
        LIF_INTEGRATE: begin
          if (fire) begin
            v     <= '0;
            spike <= 1'b1;
            if (REFRAC_CYCLES > 0) begin
              cnt   <= CNT_W'(REFRAC_CYCLES);
              state <= LIF_REFRAC;
            end
          end else begin
            v     <= v_next;
            spike <= 1'b0;
          end
        end
        LIF_REFRAC: begin
          v     <= '0;
          spike <= 1'b0;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= LIF_INTEGRATE;
        end
        default: begin
          state <= LIF_INTEGRATE;
          spike <= 1'b0;
        end
      endcase
    end else begin
      spike <= 1'b0;
    end
  end

  assign v_mem  = v;
  assign refrac = (state == LIF_REFRAC);

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] scnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt <= '0;
    end else if (cnt_clr) begin
      scnt <= '0;
    end else if (en && state == LIF_INTEGRATE && fire && scnt != 8'hFF) begin
      scnt <= scnt + 8'd1;
    end
  end

  assign spike_cnt = scnt;
`endif

endmodule

// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - N_CH independent LIF neurons sharing one threshold
// Spike counters per channel are added when LIF_SPIKE_COUNT_EN is defined.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int WIDTH         = LIF_WIDTH,
  parameter int N_CH          = LIF_N_CH,
  parameter int LEAK_SHIFT    = LIF_LEAK_SHIFT,
  parameter int REFRAC_CYCLES = LIF_REFRAC_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  lif_neuron_array_if.slave io
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    lif_channel #(
      .WIDTH         (WIDTH),
      .LEAK_SHIFT    (LEAK_SHIFT),
      .REFRAC_CYCLES (REFRAC_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (io.en),
      .i_syn     (io.i_syn[k*WIDTH +: WIDTH]),
      .thresh    (io.thresh),
`ifdef LIF_SPIKE_COUNT_EN
      .cnt_clr   (io.cnt_clr),
      .spike_cnt (io.spike_cnt[k*8 +: 8]),
`endif
      .v_mem     (io.v_mem[k*WIDTH +: WIDTH]),
      .spike     (io.spike[k]),
      .refrac    (io.refrac[k])
    );
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - randomized and directed checks of lif_neuron_array against a behavioural model
// Spike-counter checks compile in when LIF_SPIKE_COUNT_EN is defined.
module tb_lif_neuron_array;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int RC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  int mv [N];
  int mref [N];
  int msp [N];
  int mcnt [N];

  always #5 clk = ~clk;

  lif_neuron_array_if #(.WIDTH(W), .N_CH(N)) bus ();

  lif_neuron_array #(
    .WIDTH(W), .N_CH(N), .LEAK_SHIFT(3), .REFRAC_CYCLES(RC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      mv[c] = 0; mref[c] = 0; msp[c] = 0;
`ifdef LIF_SPIKE_COUNT_EN
      mcnt[c] = 0;
`endif
    end
  endtask

  // Refractory is modelled as "cycles still owed"; nonzero means held at 0.
  task automatic model_step(input bit e, input int i0, input int i1, input int th, input bit clr);
    int in [N];
    int nv;
    in[0] = i0; in[1] = i1;
    for (int c = 0; c < N; c++) begin
      if (!e) begin
        msp[c] = 0;
      end else if (mref[c] > 0) begin
        mv[c] = 0; msp[c] = 0; mref[c]--;
      end else begin
        nv = mv[c] - mv[c] / 8 + in[c];
        if (nv > 255) nv = 255;
        if (th != 0 && nv >= th) begin
          mv[c] = 0; msp[c] = 1; mref[c] = RC;
        end else begin
          mv[c] = nv; msp[c] = 0;
        end
      end
`ifdef LIF_SPIKE_COUNT_EN
      if (clr) mcnt[c] = 0;
      else if (msp[c] == 1 && mcnt[c] < 255) mcnt[c]++;
`endif
    end
  endtask

  task automatic compare_all(input string tag);
    for (int c = 0; c < N; c++) begin
      check($sformatf("%s v_mem[%0d]", tag, c), int'(bus.v_mem[c*W +: W]), mv[c]);
      check($sformatf("%s spike[%0d]", tag, c), int'(bus.spike[c]), msp[c]);
      check($sformatf("%s refrac[%0d]", tag, c), int'(bus.refrac[c]), int'(mref[c] > 0));
`ifdef LIF_SPIKE_COUNT_EN
      check($sformatf("%s spike_cnt[%0d]", tag, c), int'(bus.spike_cnt[c*8 +: 8]), mcnt[c]);
`endif
    end
  endtask

  task automatic step(input string tag, input bit e, input int i0, input int i1, input int th, input bit clr);
    bus.en     = e;
    bus.i_syn  = {W'(i1), W'(i0)};
    bus.thresh = W'(th);
`ifdef LIF_SPIKE_COUNT_EN
    bus.cnt_clr = clr;
`endif
    @(posedge clk);
    #1;
    model_step(e, i0, i1, th, clr);
    compare_all(tag);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int ramp_v [11] = '{50, 94, 133, 167, 197, 0, 0, 0, 0, 0, 50};
    int ramp_s [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int ramp_r [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int leak_v [3]  = '{147, 129, 113};
    int th;

    bus.en = 1'b0; bus.i_syn = '0; bus.thresh = 8'd200;
`ifdef LIF_SPIKE_COUNT_EN
    bus.cnt_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    compare_all("por");

    // Ramp to threshold, fire, sit out the refractory window, resume.
    for (int k = 0; k < 11; k++) begin
      step("ramp", 1'b1, 50, 0, 200, 1'b0);
      check($sformatf("ramp_v%0d", k), int'(bus.v_mem[7:0]), ramp_v[k]);
      check($sformatf("ramp_s%0d", k), int'(bus.spike[0]), ramp_s[k]);
      check($sformatf("ramp_r%0d", k), int'(bus.refrac[0]), ramp_r[k]);
    end

    // Async reset mid-refractory drops everything before the next edge.
    do_reset();
    for (int k = 0; k < 6; k++) step("pre_rst", 1'b1, 50, 0, 200, 1'b0);
    check("mid_refrac", int'(bus.refrac[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_v", int'(bus.v_mem), 0);
    check("rst_spike", int'(bus.spike), 0);
    check("rst_refrac", int'(bus.refrac), 0);
    rst_n = 1'b1;
    model_reset();
    step("post_rst", 1'b1, 50, 0, 200, 1'b0);
    check("post_rst_integrate", int'(bus.v_mem[7:0]), 50);

    // Leak only.
    do_reset();
    for (int k = 0; k < 4; k++) step("leak_up", 1'b1, 50, 0, 200, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("leak", 1'b1, 0, 0, 200, 1'b0);
      check($sformatf("leak_v%0d", k), int'(bus.v_mem[7:0]), leak_v[k]);
    end

    // Saturation with firing disabled.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step("sat", 1'b1, 255, 255, 0, 1'b0);
      check($sformatf("sat_v%0d", k), int'(bus.v_mem[7:0]), 255);
      check($sformatf("sat_s%0d", k), int'(bus.spike), 0);
    end

    // Enable gap delays ch0's spike by exactly the gap length.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step("en_gap", !(k >= 2 && k <= 4), 50, 0, 200, 1'b0);
      if (k >= 2 && k <= 4) check($sformatf("hold_v%0d", k), int'(bus.v_mem[7:0]), 94);
      check($sformatf("gap_ch1_v%0d", k), int'(bus.v_mem[15:8]), 0);
      check($sformatf("gap_s%0d", k), int'(bus.spike[0]), int'(k == 8));
    end

`ifdef LIF_SPIKE_COUNT_EN
    do_reset();
    for (int k = 0; k < 300 * (RC + 1); k++) step("cnt", 1'b1, 255, 0, 1, 1'b0);
    check("cnt_sat", int'(bus.spike_cnt[7:0]), 255);
    check("cnt_sat_spike", int'(bus.spike[0]), 0);
    step("clr_spike", 1'b1, 255, 0, 1, 1'b1);
    check("clr_coincident_spike", int'(bus.spike[0]), 1);
    check("clr_cnt", int'(bus.spike_cnt[7:0]), 0);
`endif

    // Random traffic with occasional threshold changes.
    do_reset();
    th = 200;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: th = 0;
          1: th = 255;
          default: th = $urandom_range(1, 255);
        endcase
      end
      step("rand", $urandom_range(0, 7) != 0,
           ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255),
           $urandom_range(0, 80), th, $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
